// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with registered read data,
// registered occupancy flags and sticky overflow/underflow.
module param_fifo #(
  parameter int DATA_WIDTH = 48,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    write_enable,
  input  logic                    read_enable,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dv_q, dv_d;

  logic wr_acc;
  logic rd_acc;

  // Acceptance uses the flags registered at the start of the cycle.
  assign wr_acc = write_enable && !full_q;
  assign rd_acc = read_enable && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dout_d   = dout_q;
    dv_d     = 1'b0;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        dout_d   = mem_q[rd_ptr_q];
        dv_d     = 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (write_enable && full_q) begin
        ovf_d = 1'b1;
      end
      if (read_enable && empty_q) begin
        unf_d = 1'b1;
      end
    end

    // Flags follow the next count so they never lag it.
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
    end
  end

  // Storage is never reset; unread entries are unobservable.
  always_ff @(posedge clk) begin
    if (reset_n && !clear && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = dout_q;
  assign data_valid   = dv_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: directed vector table,
// corner sequences and randomized traffic against a queue model.
module tb_param_fifo;

  localparam int DW  = 48;
  localparam int DEP = 4;
  localparam int AF  = 3;
  localparam int AE  = 1;

  logic          clk;
  logic          reset_n;
  logic          clear;
  logic          write_enable;
  logic          read_enable;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [2:0]    count;
  logic          overflow;
  logic          underflow;

  param_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEP),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clear(clear),
    .write_enable(write_enable),
    .read_enable(read_enable),
    .data_in(data_in),
    .data_out(data_out),
    .data_valid(data_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural reference: a plain queue of words.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_dout;
  logic          m_dv;
  logic          m_ovf;
  logic          m_unf;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit clr,
                            input bit we, input bit re,
                            input logic [DW-1:0] din);
    bit wa;
    bit ra;
    if (!rst) begin
      mq.delete();
      m_dout = '0;
      m_dv   = 0;
      m_ovf  = 0;
      m_unf  = 0;
    end else if (clr) begin
      mq.delete();
      m_dv  = 0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      wa   = we && (mq.size() < DEP);
      ra   = re && (mq.size() > 0);
      m_dv = ra;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(din);
      if (we && !wa) m_ovf = 1;
      if (re && !ra) m_unf = 1;
    end
  endtask

  task automatic cyc(input bit rst, input bit clr,
                     input bit we, input bit re,
                     input logic [DW-1:0] din);
    reset_n      = rst;
    clear        = clr;
    write_enable = we;
    read_enable  = re;
    data_in      = din;
    @(posedge clk);
    #1;
    model_step(rst, clr, we, re, din);
  endtask

  function automatic logic [9:0] dut_stat();
    return {count, full, empty, almost_full, almost_empty,
            overflow, underflow, data_valid};
  endfunction

  function automatic logic [9:0] model_stat();
    int n;
    n = mq.size();
    return {3'(n), n == DEP, n == 0, n >= AF, n <= AE,
            m_ovf, m_unf, m_dv};
  endfunction

  task automatic mchk(input string nm);
    chk({nm, "_stat"}, 64'(dut_stat()), 64'(model_stat()));
    chk({nm, "_dout"}, 64'(data_out), 64'(m_dout));
  endtask

  task automatic mcyc(input string nm, input bit rst, input bit clr,
                      input bit we, input bit re,
                      input logic [DW-1:0] din);
    cyc(rst, clr, we, re, din);
    mchk(nm);
  endtask

  typedef struct {
    bit            rst;
    bit            we;
    bit            re;
    logic [DW-1:0] din;
    logic [2:0]    e_cnt;
    bit            e_full;
    bit            e_empty;
    bit            e_af;
    bit            e_ae;
    bit            e_ovf;
    bit            e_unf;
    bit            e_dv;
    logic [DW-1:0] e_dout;
  } vec_t;

  vec_t tbl [12];

  initial begin
    reset_n      = 1'b0;
    clear        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    data_in      = '0;

    //         rst we re din   cnt F E AF AE ov un dv dout
    tbl[0]  = '{0, 0, 0, 'h00, 0, 0, 1, 0, 1, 0, 0, 0, 'h00};
    tbl[1]  = '{1, 1, 0, 'hA1, 1, 0, 0, 0, 1, 0, 0, 0, 'h00};
    tbl[2]  = '{1, 1, 0, 'hA2, 2, 0, 0, 0, 0, 0, 0, 0, 'h00};
    tbl[3]  = '{1, 1, 0, 'hA3, 3, 0, 0, 1, 0, 0, 0, 0, 'h00};
    tbl[4]  = '{1, 1, 0, 'hA4, 4, 1, 0, 1, 0, 0, 0, 0, 'h00};
    tbl[5]  = '{1, 1, 0, 'hA5, 4, 1, 0, 1, 0, 1, 0, 0, 'h00};
    tbl[6]  = '{1, 0, 1, 'h00, 3, 0, 0, 1, 0, 1, 0, 1, 'hA1};
    tbl[7]  = '{1, 0, 1, 'h00, 2, 0, 0, 0, 0, 1, 0, 1, 'hA2};
    tbl[8]  = '{1, 0, 1, 'h00, 1, 0, 0, 0, 1, 1, 0, 1, 'hA3};
    tbl[9]  = '{1, 0, 1, 'h00, 0, 0, 1, 0, 1, 1, 0, 1, 'hA4};
    tbl[10] = '{1, 0, 1, 'h00, 0, 0, 1, 0, 1, 1, 1, 0, 'hA4};
    tbl[11] = '{1, 0, 0, 'h00, 0, 0, 1, 0, 1, 1, 1, 0, 'hA4};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].rst, 0, tbl[i].we, tbl[i].re, tbl[i].din);
      chk($sformatf("tbl%0d_stat", i), 64'(dut_stat()),
          64'({tbl[i].e_cnt, tbl[i].e_full, tbl[i].e_empty,
               tbl[i].e_af, tbl[i].e_ae, tbl[i].e_ovf,
               tbl[i].e_unf, tbl[i].e_dv}));
      chk($sformatf("tbl%0d_dout", i), 64'(data_out),
          64'(tbl[i].e_dout));
    end

    // Streaming through several pointer wraps.
    mcyc("strm_rst", 0, 0, 0, 0, '0);
    for (int r = 0; r < 5; r++) begin
      mcyc("strm_w", 1, 0, 1, 0, 48'h100 + 48'(2 * r));
      mcyc("strm_w", 1, 0, 1, 0, 48'h101 + 48'(2 * r));
      mcyc("strm_r", 1, 0, 0, 1, '0);
      chk("strm_order0", 64'(data_out), 64'(48'h100 + 48'(2 * r)));
      mcyc("strm_r", 1, 0, 0, 1, '0);
      chk("strm_order1", 64'(data_out), 64'(48'h101 + 48'(2 * r)));
    end
    chk("strm_noflags", 64'({overflow, underflow}), 64'(0));

    // Simultaneous read/write at count 2.
    mcyc("rw_a", 1, 0, 1, 0, 48'hB0);
    mcyc("rw_b", 1, 0, 1, 0, 48'hB1);
    for (int k = 0; k < 5; k++) begin
      mcyc("rw2", 1, 0, 1, 1, 48'hB2 + 48'(k));
      chk("rw2_count", 64'(count), 64'(2));
      chk("rw2_order", 64'(data_out), 64'(48'hB0 + 48'(k)));
    end

    // Simultaneous read/write while full, then while empty.
    mcyc("rwf_fill", 1, 0, 1, 0, 48'hC0);
    mcyc("rwf_fill", 1, 0, 1, 0, 48'hC1);
    mcyc("rwf", 1, 0, 1, 1, 48'hC2);
    chk("rwf_count", 64'(count), 64'(DEP - 1));
    chk("rwf_ovf", 64'(overflow), 64'(1));
    for (int k = 0; k < 3; k++) mcyc("rwe_drain", 1, 0, 0, 1, '0);
    mcyc("rwe", 1, 0, 1, 1, 48'hC3);
    chk("rwe_count", 64'(count), 64'(1));
    chk("rwe_unf", 64'(underflow), 64'(1));

    // Clear with a write at count 3 and overflow set.
    mcyc("clr_rst", 0, 0, 0, 0, '0);
    for (int k = 0; k < 5; k++) mcyc("clr_fill", 1, 0, 1, 0, 48'hD0 + 48'(k));
    mcyc("clr_rd", 1, 0, 0, 1, '0);
    mcyc("clr_go", 1, 1, 1, 0, 48'hDD);
    chk("clr_count", 64'({count, empty, overflow}), 64'({3'd0, 1'b1, 1'b0}));
    mcyc("clr_after", 1, 0, 0, 1, '0);

    // Same scenario with reset instead of clear.
    for (int k = 0; k < 5; k++) mcyc("rst_fill", 1, 0, 1, 0, 48'hE0 + 48'(k));
    mcyc("rst_rd", 1, 0, 0, 1, '0);
    mcyc("rst_go", 0, 0, 1, 0, 48'hEE);
    chk("rst_count", 64'({count, empty, overflow}), 64'({3'd0, 1'b1, 1'b0}));
    mcyc("rst_first_wr", 1, 0, 1, 0, 48'hEF);
    chk("rst_first_cnt", 64'(count), 64'(1));

    // Randomized traffic with varying fill bias.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = ((i / 40) % 2) ? 75 : 30;
      mcyc("rnd",
           $urandom_range(0, 99) != 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 99) < bias,
           $urandom_range(0, 99) >= bias - 10,
           {$urandom(), $urandom()} >> 16);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
